// File: rtl/memory_stage.sv
// memory_stage: pipeline stage after execute. Performs loads/stores on an
// internal word-addressed array with a fixed multi-cycle latency, stalls the
// upstream stage while busy and registers results toward writeback.
// Optional feature macro: MEM_FAULT_EN (adds mem_fault_out; accesses whose
// upper address bits are non-zero are suppressed and flagged).
module memory_stage #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] alu_in,
  input  logic [15:0] memory_data_in,
  input  logic        memory_we_in,
  input  logic        writeback_src_in,
  input  logic        writeback_en_in,
  input  logic [2:0]  writeback_address_in,
  output logic [15:0] alu_out,
  output logic [15:0] memory_read_data_out,
  output logic        writeback_src_out,
  output logic        writeback_en_out,
  output logic [2:0]  writeback_address_out,
`ifdef MEM_FAULT_EN
  output logic        mem_fault_out,
`endif
  output logic        stall_out
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        alu_lat_q, alu_lat_d;
  logic [15:0]        data_q, data_d;
  logic               we_q, we_d;
  logic               src_q, src_d;
  logic               wen_q, wen_d;
  logic [2:0]         wa_q, wa_d;
  logic [15:0]        alu_out_q, alu_out_d;
  logic [15:0]        rd_q, rd_d;
  logic               src_out_q, src_out_d;
  logic               wen_out_q, wen_out_d;
  logic [2:0]         wa_out_q, wa_out_d;
  logic               fault_q, fault_d;
  logic               mem_wr_s;
  logic               mem_op_s;
  logic [ADDR_W-1:0]  addr_s;

  // Data array; deliberately not reset, contents undefined until written.
  logic [15:0] mem_q [0:(2**ADDR_W)-1];

  assign mem_op_s = memory_we_in | writeback_src_in;
  assign addr_s   = alu_lat_q[ADDR_W-1:0];

  // Next-state, latch and output computation for the IDLE/BUSY controller.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_lat_d = alu_lat_q;
    data_d    = data_q;
    we_d      = we_q;
    src_d     = src_q;
    wen_d     = wen_q;
    wa_d      = wa_q;
    alu_out_d = alu_out_q;
    rd_d      = rd_q;
    src_out_d = src_out_q;
    wen_out_d = wen_out_q;
    wa_out_d  = wa_out_q;
    fault_d   = 1'b0;
    mem_wr_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          // Accept the op, latch it, and issue a bubble while the access runs.
          alu_lat_d = alu_in;
          data_d    = memory_data_in;
          we_d      = memory_we_in;
          src_d     = writeback_src_in;
          wen_d     = writeback_en_in;
          wa_d      = writeback_address_in;
          cnt_d     = 4'(MEM_LATENCY - 1);
          state_d   = BUSY;
          wen_out_d = 1'b0;
        end else begin
          alu_out_d = alu_in;
          rd_d      = 16'h0000;
          src_out_d = writeback_src_in;
          wen_out_d = writeback_en_in;
          wa_out_d  = writeback_address_in;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d   = IDLE;
          alu_out_d = alu_lat_q;
          src_out_d = src_q;
          wen_out_d = wen_q;
          wa_out_d  = wa_q;
          // A store takes precedence over a load when both are requested.
          if (we_q) begin
            mem_wr_s = 1'b1;
            rd_d     = 16'h0000;
          end else begin
            rd_d     = mem_q[addr_s];
          end
`ifdef MEM_FAULT_EN
          if (|alu_lat_q[15:ADDR_W]) begin
            mem_wr_s  = 1'b0;
            rd_d      = 16'h0000;
            wen_out_d = 1'b0;
            fault_d   = 1'b1;
          end else begin
            fault_d   = 1'b0;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      alu_lat_q <= 16'h0000;
      data_q    <= 16'h0000;
      we_q      <= 1'b0;
      src_q     <= 1'b0;
      wen_q     <= 1'b0;
      wa_q      <= 3'd0;
      alu_out_q <= 16'h0000;
      rd_q      <= 16'h0000;
      src_out_q <= 1'b0;
      wen_out_q <= 1'b0;
      wa_out_q  <= 3'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_lat_q <= alu_lat_d;
      data_q    <= data_d;
      we_q      <= we_d;
      src_q     <= src_d;
      wen_q     <= wen_d;
      wa_q      <= wa_d;
      alu_out_q <= alu_out_d;
      rd_q      <= rd_d;
      src_out_q <= src_out_d;
      wen_out_q <= wen_out_d;
      wa_out_q  <= wa_out_d;
      fault_q   <= fault_d;
    end
  end

  // Array write port; a reset in the completing cycle discards the store.
  always_ff @(posedge clk) begin
    if (mem_wr_s && !rst) begin
      mem_q[addr_s] <= data_q;
    end
  end

  assign alu_out               = alu_out_q;
  assign memory_read_data_out  = rd_q;
  assign writeback_src_out     = src_out_q;
  assign writeback_en_out      = wen_out_q;
  assign writeback_address_out = wa_out_q;
  assign stall_out             = (state_q == BUSY);
`ifdef MEM_FAULT_EN
  assign mem_fault_out         = fault_q;
`else
  // Fault flag has no consumer when the feature is disabled.
  logic unused_fault_s;
  assign unused_fault_s        = fault_q;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage (ADDR_W=8, MEM_LATENCY=2).
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_in;
  logic [15:0] memory_data_in;
  logic        memory_we_in;
  logic        writeback_src_in;
  logic        writeback_en_in;
  logic [2:0]  writeback_address_in;
  logic [15:0] alu_out;
  logic [15:0] memory_read_data_out;
  logic        writeback_src_out;
  logic        writeback_en_out;
  logic [2:0]  writeback_address_out;
  logic        stall_out;
`ifdef MEM_FAULT_EN
  logic        mem_fault_out;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic [15:0] mem_model [0:255];

  memory_stage #(.ADDR_W(8), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .alu_in(alu_in), .memory_data_in(memory_data_in),
    .memory_we_in(memory_we_in), .writeback_src_in(writeback_src_in),
    .writeback_en_in(writeback_en_in), .writeback_address_in(writeback_address_in),
    .alu_out(alu_out), .memory_read_data_out(memory_read_data_out),
    .writeback_src_out(writeback_src_out), .writeback_en_out(writeback_en_out),
    .writeback_address_out(writeback_address_out),
`ifdef MEM_FAULT_EN
    .mem_fault_out(mem_fault_out),
`endif
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] a, input logic [15:0] d, input logic we,
                        input logic src, input logic wen, input logic [2:0] wa);
    alu_in = a; memory_data_in = d; memory_we_in = we;
    writeback_src_in = src; writeback_en_in = wen; writeback_address_in = wa;
  endtask

  // Present an op, hold it through any stall, return stall cycles and bubble status.
  task automatic do_op(input logic [15:0] a, input logic [15:0] d, input logic we,
                       input logic src, input logic wen, input logic [2:0] wa,
                       output int n, output logic bub_ok);
    set_in(a, d, we, src, wen, wa);
    bub_ok = 1'b1;
    step();
    n = 0;
    while (stall_out === 1'b1 && n < 40) begin
      n++;
      if (writeback_en_out !== 1'b0) bub_ok = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
    step();
    set_in(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
    step();
    tests_run++;
    if ({alu_out, memory_read_data_out, writeback_src_out, writeback_en_out,
         writeback_address_out, stall_out} !== 38'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got alu=%h rd=%h src=%b wen=%b wa=%0d stall=%b, want all 0",
               alu_out, memory_read_data_out, writeback_src_out, writeback_en_out,
               writeback_address_out, stall_out);
    end
`ifdef MEM_FAULT_EN
    tests_run++;
    if (mem_fault_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fault: got %b want 0", mem_fault_out);
    end
`endif
    set_in(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    int n; logic b;
    do_op(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3, n, b);
    tests_run++;
    if (n !== 0) begin tests_failed++; $display("FAIL pass_stall: got %0d want 0", n); end
    tests_run++;
    if ({alu_out, writeback_en_out, writeback_address_out, writeback_src_out, memory_read_data_out}
        !== {16'h1234, 1'b1, 3'd3, 1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL pass_outputs: got alu=%h wen=%b wa=%0d src=%b rd=%h want 1234 1 3 0 0000",
               alu_out, writeback_en_out, writeback_address_out, writeback_src_out, memory_read_data_out);
    end
  endtask

  task automatic test_store_load();
    int n; logic b;
    do_op(16'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b0, 3'd1, n, b);
    mem_model[8'h10] = 16'hBEEF;
    tests_run++;
    if (n !== 2 || b !== 1'b1 || writeback_en_out !== 1'b0 || memory_read_data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL store: got stall=%0d bubble=%b wen=%b rd=%h want 2 1 0 0000",
               n, b, writeback_en_out, memory_read_data_out);
    end
    do_op(16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd5, n, b);
    tests_run++;
    if (n !== 2 || b !== 1'b1) begin
      tests_failed++; $display("FAIL load_stall: got stall=%0d bubble=%b want 2 1", n, b);
    end
    tests_run++;
    if ({memory_read_data_out, writeback_src_out, writeback_en_out, writeback_address_out}
        !== {mem_model[8'h10], 1'b1, 1'b1, 3'd5}) begin
      tests_failed++;
      $display("FAIL load_data: got rd=%h src=%b wen=%b wa=%0d want %h 1 1 5",
               memory_read_data_out, writeback_src_out, writeback_en_out,
               writeback_address_out, mem_model[8'h10]);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2, n3, c0, c2; logic b;
    c0 = cyc;
    do_op(16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd2, n1, b);
    c0 = cyc;
    do_op(16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd4, n2, b);
    c2 = cyc;
    tests_run++;
    if (c2 - c0 !== 3) begin
      tests_failed++; $display("FAIL b2b_second_load: got %0d cycles want 3", c2 - c0);
    end
    tests_run++;
    if (memory_read_data_out !== mem_model[8'h10] || writeback_address_out !== 3'd4) begin
      tests_failed++;
      $display("FAIL b2b_load_data: got rd=%h wa=%0d want %h 4",
               memory_read_data_out, writeback_address_out, mem_model[8'h10]);
    end
    do_op(16'h0042, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd6, n3, b);
    tests_run++;
    if (cyc - c2 !== 1 || alu_out !== 16'h0042 || writeback_en_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_alu: got delay=%0d alu=%h wen=%b want 1 0042 1", cyc - c2, alu_out, writeback_en_out);
    end
    tests_run++;
    if (n1 + n2 + n3 !== 4) begin
      tests_failed++; $display("FAIL b2b_stalls: got %0d want 4", n1 + n2 + n3);
    end
  endtask

  task automatic test_reset_mid_store();
    int n; logic b;
    do_op(16'h0020, 16'h1111, 1'b1, 1'b0, 1'b0, 3'd0, n, b);
    mem_model[8'h20] = 16'h1111;
    set_in(16'h0020, 16'h2222, 1'b1, 1'b0, 1'b1, 3'd7);
    step();
    rst = 1'b1;
    step();
    tests_run++;
    if ({alu_out, memory_read_data_out, writeback_src_out, writeback_en_out,
         writeback_address_out, stall_out} !== 38'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got alu=%h rd=%h src=%b wen=%b wa=%0d stall=%b want all 0",
               alu_out, memory_read_data_out, writeback_src_out, writeback_en_out,
               writeback_address_out, stall_out);
    end
    set_in(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    do_op(16'h0020, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd1, n, b);
    tests_run++;
    if (memory_read_data_out !== mem_model[8'h20]) begin
      tests_failed++;
      $display("FAIL midreset_load: got %h want %h", memory_read_data_out, mem_model[8'h20]);
    end
  endtask

  task automatic test_fault();
    int n; logic b;
    do_op(16'h0110, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd2, n, b);
    tests_run++;
    if (n !== 2) begin tests_failed++; $display("FAIL fault_stall: got %0d want 2", n); end
`ifdef MEM_FAULT_EN
    tests_run++;
    if ({mem_fault_out, writeback_en_out, memory_read_data_out} !== {1'b1, 1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL fault_flag: got fault=%b wen=%b rd=%h want 1 0 0000",
               mem_fault_out, writeback_en_out, memory_read_data_out);
    end
    do_op(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, n, b);
    tests_run++;
    if (mem_fault_out !== 1'b0) begin
      tests_failed++; $display("FAIL fault_clear: got %b want 0", mem_fault_out);
    end
`else
    tests_run++;
    if (memory_read_data_out !== mem_model[8'h10] || writeback_en_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL upper_ignored: got rd=%h wen=%b want %h 1",
               memory_read_data_out, writeback_en_out, mem_model[8'h10]);
    end
`endif
  endtask

  task automatic test_random();
    int n; logic b;
    logic [15:0] a, d, exp_rd;
    logic [7:0] ad;
    logic we, src, wen;
    logic [2:0] wa;
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      do_op(16'h0040 + 16'(i), d, 1'b1, 1'b0, 1'b0, 3'd0, n, b);
      mem_model[8'h40 + 8'(i)] = d;
    end
    for (int i = 0; i < 60; i++) begin
      ad  = 8'h40 + 8'($urandom_range(0, 7));
      d   = 16'($urandom);
      wen = 1'($urandom);
      wa  = 3'($urandom);
      case ($urandom_range(0, 3))
        0: begin we = 1'b0; src = 1'b0; end
        1: begin we = 1'b1; src = 1'b0; end
        2: begin we = 1'b0; src = 1'b1; end
        default: begin we = 1'b1; src = 1'b1; end
      endcase
`ifdef MEM_FAULT_EN
      a = (we | src) ? {8'h00, ad} : 16'($urandom);
`else
      a = (we | src) ? {8'($urandom), ad} : 16'($urandom);
`endif
      exp_rd = (src && !we) ? mem_model[ad] : 16'h0000;
      do_op(a, d, we, src, wen, wa, n, b);
      if (we) mem_model[ad] = d;
      tests_run++;
      if (n !== ((we | src) ? 2 : 0) || b !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand_stall[%0d]: got stall=%0d bubble=%b want %0d 1", i, n, b, (we | src) ? 2 : 0);
      end
      tests_run++;
      if ({alu_out, memory_read_data_out, writeback_src_out, writeback_en_out, writeback_address_out}
          !== {a, exp_rd, src, wen, wa}) begin
        tests_failed++;
        $display("FAIL rand_out[%0d]: got alu=%h rd=%h src=%b wen=%b wa=%0d want %h %h %b %b %0d",
                 i, alu_out, memory_read_data_out, writeback_src_out, writeback_en_out,
                 writeback_address_out, a, exp_rd, src, wen, wa);
      end
`ifdef MEM_FAULT_EN
      tests_run++;
      if (mem_fault_out !== 1'b0) begin
        tests_failed++; $display("FAIL rand_fault[%0d]: got %b want 0", i, mem_fault_out);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
    test_reset();
    test_passthrough();
    test_store_load();
    test_back_to_back();
    test_reset_mid_store();
    test_fault();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
